// File: rtl/inst_pkg.sv
// -----------------------------------------------------------------------------
// inst_pkg -- shared encoding constants for the RV32I decoder/encoder pair.
//
// Contents:
//   ALU_*      : ALU operation codes carried on alucode[5:0]
//   OP_TYPE_*  : operand source codes carried on aluop1_type / aluop2_type
//   OP_*       : RV32I major opcodes
//   F3_* / F7_*: funct3 / funct7 field values
//   inst_fmt_t : instruction format (R, I, S, B, U, J)
//   enc_req_t  : one encode request as captured by the input stage
//   alu_funct3 : funct3 lookup for any ALU code that has one
//   fits_signed: true when a 32-bit value is a sign extension of N bits
// -----------------------------------------------------------------------------
package inst_pkg;

   // ALU operation codes (decoder output encoding)
   localparam logic [5:0] ALU_NOP  = 6'd0;
   localparam logic [5:0] ALU_ADD  = 6'd1;
   localparam logic [5:0] ALU_SUB  = 6'd2;
   localparam logic [5:0] ALU_SLL  = 6'd3;
   localparam logic [5:0] ALU_SLT  = 6'd4;
   localparam logic [5:0] ALU_SLTU = 6'd5;
   localparam logic [5:0] ALU_XOR  = 6'd6;
   localparam logic [5:0] ALU_SRL  = 6'd7;
   localparam logic [5:0] ALU_SRA  = 6'd8;
   localparam logic [5:0] ALU_OR   = 6'd9;
   localparam logic [5:0] ALU_AND  = 6'd10;
   localparam logic [5:0] ALU_LUI  = 6'd11;
   localparam logic [5:0] ALU_JAL  = 6'd12;
   localparam logic [5:0] ALU_JALR = 6'd13;
   localparam logic [5:0] ALU_BEQ  = 6'd14;
   localparam logic [5:0] ALU_BNE  = 6'd15;
   localparam logic [5:0] ALU_BLT  = 6'd16;
   localparam logic [5:0] ALU_BGE  = 6'd17;
   localparam logic [5:0] ALU_BLTU = 6'd18;
   localparam logic [5:0] ALU_BGEU = 6'd19;
   localparam logic [5:0] ALU_SB   = 6'd20;
   localparam logic [5:0] ALU_SH   = 6'd21;
   localparam logic [5:0] ALU_SW   = 6'd22;
   localparam logic [5:0] ALU_LB   = 6'd23;
   localparam logic [5:0] ALU_LH   = 6'd24;
   localparam logic [5:0] ALU_LW   = 6'd25;
   localparam logic [5:0] ALU_LBU  = 6'd26;
   localparam logic [5:0] ALU_LHU  = 6'd27;

   // Operand source codes
   localparam logic [1:0] OP_TYPE_NONE = 2'd0;
   localparam logic [1:0] OP_TYPE_REG  = 2'd1;
   localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
   localparam logic [1:0] OP_TYPE_PC   = 2'd3;

   // RV32I major opcodes
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;

   // funct3 groups (one value serves several instruction classes)
   localparam logic [2:0] F3_000 = 3'b000;  // ADD/SUB BEQ SB LB JALR
   localparam logic [2:0] F3_001 = 3'b001;  // SLL BNE SH LH
   localparam logic [2:0] F3_010 = 3'b010;  // SLT SW LW
   localparam logic [2:0] F3_011 = 3'b011;  // SLTU
   localparam logic [2:0] F3_100 = 3'b100;  // XOR BLT LBU
   localparam logic [2:0] F3_101 = 3'b101;  // SRL/SRA BGE LHU
   localparam logic [2:0] F3_110 = 3'b110;  // OR BLTU
   localparam logic [2:0] F3_111 = 3'b111;  // AND BGEU

   // funct7: ALT selects SUB / SRA (sets inst[30])
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } inst_fmt_t;

   typedef struct packed {
      logic [5:0]  alucode;
      logic [1:0]  aluop1_type;
      logic [1:0]  aluop2_type;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } enc_req_t;

   function automatic logic [2:0] alu_funct3(input logic [5:0] alu);
      logic [2:0] f3;
      f3 = F3_000;
      case (alu)
         ALU_SLL, ALU_BNE, ALU_SH, ALU_LH:           f3 = F3_001;
         ALU_SLT, ALU_SW, ALU_LW:                    f3 = F3_010;
         ALU_SLTU:                                   f3 = F3_011;
         ALU_XOR, ALU_BLT, ALU_LBU:                  f3 = F3_100;
         ALU_SRL, ALU_SRA, ALU_BGE, ALU_LHU:         f3 = F3_101;
         ALU_OR, ALU_BLTU:                           f3 = F3_110;
         ALU_AND, ALU_BGEU:                          f3 = F3_111;
         default:                                    f3 = F3_000;
      endcase
      return f3;
   endfunction

   // Arithmetic shift leaves all-zeros or all-ones exactly when the upper
   // bits are copies of bit (bits-1).
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] s;
      s = $signed(v) >>> (bits - 1);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// -----------------------------------------------------------------------------
// enc_fifo -- synchronous FIFO buffering encoded words for the consumer.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push          : write push_data at the tail (never asserted when full)
//   push_data     : WIDTH-bit entry
//   pop           : drop the head entry (never asserted when empty)
//   head_data     : entry at the head (meaningful only when head_valid)
//   head_valid    : FIFO not empty
//   count         : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module enc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic                         head_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // NOTE: the storage array has no reset; count alone decides which entries
   // are live, so clearing the pointers and count is enough to discard data.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // NOTE: all state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;  // idle, or push and pop together
         endcase
      end
   end

   assign head_data  = mem[rd_ptr];
   assign head_valid = (count != '0);

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder -- turns decoder-style fields back into an RV32I word.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : request handshake; in_ready comes from registered state
//   alucode, aluop1_type, aluop2_type, rd, rs1, rs2, imm : request fields
//   out_valid/ready : FIFO head handshake
//   out_inst        : encoded word at the FIFO head (0 when not encodable)
//   out_illegal     : head request had no RV32I encoding
// Parameter DEPTH   : output FIFO entries (power of two, >= 2).
// Build option      : define ENCODER_RANGE_CHECK_EN to flag immediates that do
//                     not fit their field; otherwise they are truncated.
//
// Pipeline: the accepting edge captures the request in a stage register; the
// next edge writes the assembled word into enc_fifo, so out_valid can rise
// two edges after acceptance.
// -----------------------------------------------------------------------------
module inst_encoder
   import inst_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  alucode,
   input  logic [1:0]  aluop1_type,
   input  logic [1:0]  aluop2_type,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_illegal
);

   localparam int CW = $clog2(DEPTH + 1);

   logic       accept;
   logic       st_valid;
   enc_req_t   st_req;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   inst_fmt_t  fmt;
   logic       is_shift;
   logic       legal;
   logic       range_err;
   logic [11:0] imm_i;
   logic [31:0] asm_word;
   logic       enc_ok;

   logic [32:0]   fifo_head;
   logic          fifo_valid;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;

   // ---------------------------------------------------------------- input
   // Occupancy counts the word still in the stage, so a full pipeline never
   // pushes past DEPTH. rst gating holds in_ready low during reset and lets
   // it rise as soon as reset is released.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, st_valid};
   assign in_ready  = !rst && (occupancy < (CW+1)'(DEPTH));
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_valid <= 1'b0;
      else     st_valid <= accept;
   end

   // Payload needs no reset: st_valid qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         st_req.alucode     <= alucode;
         st_req.aluop1_type <= aluop1_type;
         st_req.aluop2_type <= aluop2_type;
         st_req.rd          <= rd;
         st_req.rs1         <= rs1;
         st_req.rs2         <= rs2;
         st_req.imm         <= imm;
      end
   end

   // -------------------------------------------------------------- decode
   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a value held (no latches).
   always_comb begin
      opcode   = 7'b0;
      funct3   = F3_000;
      funct7   = F7_BASE;
      fmt      = FMT_R;
      is_shift = 1'b0;
      legal    = 1'b1;
      case (st_req.alucode)
         ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
         ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: begin
            funct3 = alu_funct3(st_req.alucode);
            if (st_req.alucode == ALU_ADD && st_req.aluop2_type == OP_TYPE_PC) begin
               opcode = OP_AUIPC;
               fmt    = FMT_U;
            end else if (st_req.aluop1_type == OP_TYPE_REG &&
                         st_req.aluop2_type == OP_TYPE_REG) begin
               opcode = OP_OP;
               fmt    = FMT_R;
               if (st_req.alucode == ALU_SUB || st_req.alucode == ALU_SRA)
                  funct7 = F7_ALT;
            end else if (st_req.aluop1_type == OP_TYPE_REG &&
                         st_req.aluop2_type == OP_TYPE_IMM &&
                         st_req.alucode != ALU_SUB) begin
               opcode   = OP_OPIMM;
               fmt      = FMT_I;
               is_shift = (st_req.alucode == ALU_SLL) || (st_req.alucode == ALU_SRL) ||
                          (st_req.alucode == ALU_SRA);
               if (st_req.alucode == ALU_SRA) funct7 = F7_ALT;
            end else begin
               legal = 1'b0;
            end
         end
         ALU_LUI: begin
            opcode = OP_LUI;
            fmt    = FMT_U;
         end
         ALU_JAL: begin
            opcode = OP_JAL;
            fmt    = FMT_J;
         end
         ALU_JALR: begin
            opcode = OP_JALR;
            fmt    = FMT_I;
         end
         ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
            opcode = OP_BRANCH;
            fmt    = FMT_B;
            funct3 = alu_funct3(st_req.alucode);
         end
         ALU_SB, ALU_SH, ALU_SW: begin
            opcode = OP_STORE;
            fmt    = FMT_S;
            funct3 = alu_funct3(st_req.alucode);
         end
         ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: begin
            opcode = OP_LOAD;
            fmt    = FMT_I;
            funct3 = alu_funct3(st_req.alucode);
         end
         default: legal = 1'b0;  // ALU_NOP and unassigned codes
      endcase
   end

   // --------------------------------------------------------- range check
`ifdef ENCODER_RANGE_CHECK_EN
   always_comb begin
      range_err = 1'b0;
      case (fmt)
         FMT_I:   range_err = is_shift ? (st_req.imm[31:5] != '0)
                                       : !fits_signed(st_req.imm, 12);
         FMT_S:   range_err = !fits_signed(st_req.imm, 12);
         FMT_B:   range_err = !fits_signed(st_req.imm, 13) || st_req.imm[0];
         FMT_U:   range_err = (st_req.imm[11:0] != '0);
         FMT_J:   range_err = !fits_signed(st_req.imm, 21) || st_req.imm[0];
         default: range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

   // ------------------------------------------------------------ assemble
   // Shift immediates carry funct7 in the upper seven bits of the I field.
   assign imm_i = is_shift ? {funct7, st_req.imm[4:0]} : st_req.imm[11:0];

   always_comb begin
      asm_word = 32'h0;
      case (fmt)
         FMT_R: asm_word = {funct7, st_req.rs2, st_req.rs1, funct3, st_req.rd, opcode};
         FMT_I: asm_word = {imm_i, st_req.rs1, funct3, st_req.rd, opcode};
         FMT_S: asm_word = {st_req.imm[11:5], st_req.rs2, st_req.rs1, funct3,
                            st_req.imm[4:0], opcode};
         FMT_B: asm_word = {st_req.imm[12], st_req.imm[10:5], st_req.rs2, st_req.rs1,
                            funct3, st_req.imm[4:1], st_req.imm[11], opcode};
         FMT_U: asm_word = {st_req.imm[31:12], st_req.rd, opcode};
         FMT_J: asm_word = {st_req.imm[20], st_req.imm[10:1], st_req.imm[11],
                            st_req.imm[19:12], st_req.rd, opcode};
         default: asm_word = 32'h0;
      endcase
   end

   assign enc_ok = legal && !range_err;

   // -------------------------------------------------------------- buffer
   enc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (33)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (st_valid),
      .push_data  ({!enc_ok, enc_ok ? asm_word : 32'h0}),
      .pop        (fifo_valid && out_ready),
      .head_data  (fifo_head),
      .head_valid (fifo_valid),
      .count      (fifo_count)
   );

   // Outputs read as zero whenever the head is empty, including in reset,
   // so stale storage is never visible.
   assign out_valid   = fifo_valid;
   assign out_inst    = fifo_valid ? fifo_head[31:0] : 32'h0;
   assign out_illegal = fifo_valid && fifo_head[32];

endmodule
